// File: rtl/diag_log_pkg.sv
// rtl/diag_log_pkg.sv - shared types and widths for the diagnostic log scheduler
package diag_log_pkg;

   localparam int NREQ_MAX = 8;
   localparam int PAGE_W   = 8;
   localparam int VALUE_W  = 16;
   localparam int CNT_W    = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick starting one past the last granted index
module rr_pick
   import diag_log_pkg::*;
#(
   parameter int NREQ = 4
)(
   input  logic [NREQ-1:0] i_req,
   input  logic [2:0]      i_last,
   output logic [NREQ-1:0] o_grant,
   output logic [2:0]      o_idx,
   output logic            o_any
);

   logic [NREQ_MAX-1:0] w_req8;
   logic [3:0]          w_pos;

   // i_last is always below NREQ, so one conditional subtract is enough to wrap
   always_comb begin
      w_req8            = '0;
      w_req8[NREQ-1:0]  = i_req;
      w_pos             = '0;
      o_idx             = '0;
      o_any             = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         w_pos = {1'b0, i_last} + 4'(k);
         if (w_pos >= 4'(NREQ)) begin
            w_pos = w_pos - 4'(NREQ);
         end
         if (!o_any && w_req8[w_pos[2:0]]) begin
            o_any = 1'b1;
            o_idx = w_pos[2:0];
         end
      end
   end

   always_comb begin
      o_grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         o_grant[i] = o_any && (o_idx == 3'(i));
      end
   end

endmodule

// File: rtl/diag_log_scheduler.sv
// rtl/diag_log_scheduler.sv - arbitrates diagnostic samples onto a single busy-handshaked logger
module diag_log_scheduler
   import diag_log_pkg::*;
#(
   parameter int                NREQ              = 4,
   parameter int                MIN_GAP           = 16,
   parameter int                BUSY_TIMEOUT      = 64,
   parameter logic [CNT_W-1:0]  TIMEOUT_CNT_RESET = '0
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [NREQ*PAGE_W-1:0]    req_page,
   input  logic [NREQ*VALUE_W-1:0]   req_value,
   output logic [NREQ-1:0]           req_ready,
   input  logic                      i2c_busy,
   output logic                      log_new,
   output logic [PAGE_W-1:0]         log_page,
   output logic [VALUE_W-1:0]        log_value,
   output logic [2:0]                grant_idx,
   output logic                      sched_busy,
   output logic [CNT_W-1:0]          timeout_cnt
);

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     r_timeout_cnt;
   logic [PAGE_W-1:0]    r_log_page;
   logic [VALUE_W-1:0]   r_log_value;
   logic [2:0]           r_grant_idx;
   logic [2:0]           r_last_grant;

   logic [NREQ-1:0]      w_grant;
   logic [2:0]           w_pick_idx;
   logic                 w_any;
   logic                 w_accept;
   logic                 w_busy_timeout;
   logic                 w_gap_done;
   logic                 w_timeout_hit;
   logic [PAGE_W-1:0]    w_sel_page;
   logic [VALUE_W-1:0]   w_sel_value;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .i_req   (req_valid),
      .i_last  (r_last_grant),
      .o_grant (w_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_any)
   );

   // Reset gates the accept so a held requester is never granted while reset is high
   assign w_accept       = (r_state == ST_IDLE) && !reset && !i2c_busy && w_any;
   assign w_busy_timeout = (17'(r_cnt) + 17'd1) >= 17'(BUSY_TIMEOUT);
   assign w_gap_done     = (17'(r_cnt) + 17'd1) >= 17'(MIN_GAP);
   assign w_timeout_hit  = (r_state == ST_WAIT_BUSY) && !i2c_busy && w_busy_timeout;

   always_comb begin
      w_sel_page  = '0;
      w_sel_value = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel_page  = req_page[i*PAGE_W +: PAGE_W];
            w_sel_value = req_value[i*VALUE_W +: VALUE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:      if (w_accept) w_next = ST_ISSUE;
         ST_ISSUE:     w_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (i2c_busy) begin
               w_next = ST_WAIT_DONE;
            end else if (w_busy_timeout) begin
               w_next = ST_GAP;
            end
         end
         ST_WAIT_DONE: if (!i2c_busy) w_next = ST_GAP;
         ST_GAP:       if (w_gap_done) w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = w_accept ? w_grant : '0;
      log_new    = (r_state == ST_ISSUE);
      sched_busy = (r_state != ST_IDLE);
   end

   // Cycle counter restarts on every state change; only WAIT_BUSY and GAP consult it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt         <= '0;
         r_timeout_cnt <= TIMEOUT_CNT_RESET;
         r_log_page    <= '0;
         r_log_value   <= '0;
         r_grant_idx   <= '0;
         r_last_grant  <= 3'(NREQ - 1);
      end else begin
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 16'd1;
         end
         if (w_timeout_hit && (r_timeout_cnt != '1)) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
         end
         if (w_accept) begin
            r_log_page   <= w_sel_page;
            r_log_value  <= w_sel_value;
            r_grant_idx  <= w_pick_idx;
            r_last_grant <= w_pick_idx;
         end
      end
   end

   assign log_page    = r_log_page;
   assign log_value   = r_log_value;
   assign grant_idx   = r_grant_idx;
   assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_diag_log_scheduler.sv
// tb/tb_diag_log_scheduler.sv - directed bench for diag_log_scheduler
module tb_diag_log_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_page = '0;
   logic [63:0] req_value = '0;
   logic [3:0]  req_ready;
   logic        auto_busy = 1'b0;
   logic        man_busy = 1'b0;
   logic        i2c_busy;
   logic        log_new;
   logic [7:0]  log_page;
   logic [15:0] log_value;
   logic [2:0]  grant_idx;
   logic        sched_busy;
   logic [15:0] timeout_cnt;

   logic [3:0]  d2_valid = '0;
   logic [31:0] d2_page = 32'h33221100;
   logic [63:0] d2_value = 64'h0;
   logic [3:0]  d2_ready;
   logic        d2_busy = 1'b0;
   logic        d2_log_new;
   logic [7:0]  d2_log_page;
   logic [15:0] d2_log_value;
   logic [2:0]  d2_grant;
   logic        d2_sched_busy;
   logic [15:0] d2_timeout;

   bit logger_en = 1'b0;
   int n_vec = 0;
   int n_err = 0;

   assign i2c_busy = auto_busy | man_busy;

   always #5 clk = ~clk;

   diag_log_scheduler #(.NREQ(4), .MIN_GAP(16), .BUSY_TIMEOUT(64)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_page(req_page),
      .req_value(req_value), .req_ready(req_ready), .i2c_busy(i2c_busy),
      .log_new(log_new), .log_page(log_page), .log_value(log_value),
      .grant_idx(grant_idx), .sched_busy(sched_busy), .timeout_cnt(timeout_cnt)
   );

   diag_log_scheduler #(.NREQ(4), .MIN_GAP(0), .BUSY_TIMEOUT(1),
                        .TIMEOUT_CNT_RESET(16'hFFA0)) dut2 (
      .clk(clk), .reset(reset), .req_valid(d2_valid), .req_page(d2_page),
      .req_value(d2_value), .req_ready(d2_ready), .i2c_busy(d2_busy),
      .log_new(d2_log_new), .log_page(d2_log_page), .log_value(d2_log_value),
      .grant_idx(d2_grant), .sched_busy(d2_sched_busy), .timeout_cnt(d2_timeout)
   );

   // Logger model: busy rises 3 cycles after log_new and stays up for 10 cycles
   initial begin
      forever begin
         @(negedge clk);
         if (logger_en && log_new) begin
            repeat (3) @(negedge clk);
            auto_busy = 1'b1;
            repeat (10) @(negedge clk);
            auto_busy = 1'b0;
         end
      end
   end

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      d2_valid  = '0;
      man_busy  = 1'b0;
      logger_en = 1'b0;
      req_page  = 32'h13121110;
      req_value = 64'hA003_A002_A001_A000;
      repeat (15) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 4'hF;
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
      n_vec++; if (log_new !== 1'b0) begin n_err++; $display("FAIL rst_log_new: got %b want 0", log_new); end
      n_vec++; if (log_page !== 8'h00) begin n_err++; $display("FAIL rst_page: got %h want 00", log_page); end
      n_vec++; if (log_value !== 16'h0000) begin n_err++; $display("FAIL rst_value: got %h want 0000", log_value); end
      n_vec++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
      n_vec++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL rst_sched_busy: got %b want 0", sched_busy); end
      n_vec++; if (timeout_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_timeout: got %h want 0000", timeout_cnt); end
      n_vec++; if (d2_timeout !== 16'hFFA0) begin n_err++; $display("FAIL rst_d2_timeout: got %h want ffa0", d2_timeout); end
      req_valid = '0;
   endtask

   task automatic test_single();
      int extra_ready = 0;
      int extra_log = 0;
      do_reset();
      logger_en = 1'b1;
      req_page  = 32'h00000005;
      req_value = 64'h0000_0000_0000_1234;
      req_valid = 4'b0001;
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      n_vec++; if (log_new !== 1'b0) begin n_err++; $display("FAIL single_no_early_log: got %b want 0", log_new); end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (log_new !== 1'b1) begin n_err++; $display("FAIL single_log_new: got %b want 1", log_new); end
      n_vec++; if (log_page !== 8'h05) begin n_err++; $display("FAIL single_page: got %h want 05", log_page); end
      n_vec++; if (log_value !== 16'h1234) begin n_err++; $display("FAIL single_value: got %h want 1234", log_value); end
      n_vec++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL single_grant: got %0d want 0", grant_idx); end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (req_ready !== 4'b0000) extra_ready++;
         if (log_new !== 1'b0) extra_log++;
      end
      n_vec++; if (extra_ready !== 0) begin n_err++; $display("FAIL single_extra_ready: got %0d want 0", extra_ready); end
      n_vec++; if (extra_log !== 0) begin n_err++; $display("FAIL single_extra_log: got %0d want 0", extra_log); end
      n_vec++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", sched_busy); end
      n_vec++; if (timeout_cnt !== 16'h0000) begin n_err++; $display("FAIL single_timeout: got %h want 0000", timeout_cnt); end
      n_vec++; if (log_page !== 8'h05) begin n_err++; $display("FAIL single_page_held: got %h want 05", log_page); end
   endtask

   task automatic test_round_robin();
      int ngr = 0;
      int nlog = 0;
      int t_prev = 0;
      logic [3:0] exp_oh;
      do_reset();
      logger_en = 1'b1;
      req_valid = 4'hF;
      for (int c = 0; c < 250 && nlog < 5; c++) begin
         #1;
         if (req_ready !== 4'b0000) begin
            exp_oh = 4'b0001 << (ngr % 4);
            n_vec++; if (req_ready !== exp_oh) begin n_err++; $display("FAIL rr_order[%0d]: got %b want %b", ngr, req_ready, exp_oh); end
            ngr++;
         end
         if (log_new === 1'b1) begin
            n_vec++; if (log_page !== 8'(8'h10 + nlog % 4)) begin n_err++; $display("FAIL rr_page[%0d]: got %h want %h", nlog, log_page, 8'(8'h10 + nlog % 4)); end
            if (nlog > 0) begin
               n_vec++; if (c - t_prev !== 31) begin n_err++; $display("FAIL rr_spacing[%0d]: got %0d want 31", nlog, c - t_prev); end
            end
            t_prev = c;
            nlog++;
         end
         @(negedge clk);
      end
      n_vec++; if (nlog !== 5) begin n_err++; $display("FAIL rr_budget: got %0d log_new want 5", nlog); end
      req_valid = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      req_valid = 4'b0100;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL to_ready: got %b want 0100", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (log_new !== 1'b1) begin n_err++; $display("FAIL to_log_new: got %b want 1", log_new); end
      repeat (64) @(negedge clk);
      #1;
      n_vec++; if (timeout_cnt !== 16'd0) begin n_err++; $display("FAIL to_before: got %h want 0000", timeout_cnt); end
      @(negedge clk);
      #1;
      n_vec++; if (timeout_cnt !== 16'd1) begin n_err++; $display("FAIL to_after: got %h want 0001", timeout_cnt); end
      repeat (15) @(negedge clk);
      #1;
      n_vec++; if (sched_busy !== 1'b1) begin n_err++; $display("FAIL to_gap_end: got %b want 1", sched_busy); end
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      n_vec++; if (sched_busy !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b want 0", sched_busy); end
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL to_next_ready: got %b want 0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (log_new !== 1'b1) begin n_err++; $display("FAIL to_next_log: got %b want 1", log_new); end
      n_vec++; if (grant_idx !== 3'd0) begin n_err++; $display("FAIL to_next_grant: got %0d want 0", grant_idx); end
   endtask

   task automatic test_busy_hold();
      do_reset();
      man_busy  = 1'b1;
      req_valid = 4'b0010;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bh_blocked[%0d]: got %b want 0000", c, req_ready); end
         @(negedge clk);
      end
      man_busy = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bh_release: got %b want 0010", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (log_new !== 1'b1) begin n_err++; $display("FAIL bh_log_new: got %b want 1", log_new); end
      n_vec++; if (log_page !== 8'h11) begin n_err++; $display("FAIL bh_page: got %h want 11", log_page); end
      n_vec++; if (grant_idx !== 3'd1) begin n_err++; $display("FAIL bh_grant: got %0d want 1", grant_idx); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b1000;
      #1;
      n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rm_ready3: got %b want 1000", req_ready); end
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      n_vec++; if (log_page !== 8'h13) begin n_err++; $display("FAIL rm_page3: got %h want 13", log_page); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rm_issue_ready: got %b want 0000", req_ready); end
      @(negedge clk);
      man_busy = 1'b1;
      @(negedge clk);
      #1;
      n_vec++; if (sched_busy !== 1'b1 || req_ready !== 4'b0000) begin n_err++; $display("FAIL rm_wait_done: got busy=%b ready=%b want 1/0000", sched_busy, req_ready); end
      reset    = 1'b1;
      man_busy = 1'b0;
      @(negedge clk);
      #1;
      n_vec++; if (log_new !== 1'b0 || req_ready !== 4'b0000 || sched_busy !== 1'b0) begin n_err++; $display("FAIL rm_ctrl: got new=%b ready=%b busy=%b want 0/0000/0", log_new, req_ready, sched_busy); end
      n_vec++; if (log_page !== 8'h00 || log_value !== 16'h0000 || grant_idx !== 3'd0 || timeout_cnt !== 16'h0000) begin n_err++; $display("FAIL rm_data: got page=%h value=%h grant=%0d to=%h want 00/0000/0/0000", log_page, log_value, grant_idx, timeout_cnt); end
      reset = 1'b0;
      #1;
      n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rm_regrant: got %b want 0100", req_ready); end
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (log_new !== 1'b1 || log_page !== 8'h12 || grant_idx !== 3'd2) begin n_err++; $display("FAIL rm_reissue: got new=%b page=%h grant=%0d want 1/12/2", log_new, log_page, grant_idx); end
   endtask

   task automatic test_saturate();
      int nlog = 0;
      int t_prev = 0;
      do_reset();
      d2_valid = 4'b0001;
      for (int c = 0; c < 600 && nlog < 100; c++) begin
         #1;
         if (d2_log_new === 1'b1) begin
            nlog++;
            if (nlog == 2) begin
               n_vec++; if (c - t_prev !== 4) begin n_err++; $display("FAIL sat_spacing: got %0d want 4", c - t_prev); end
            end
            if (nlog == 50) begin
               n_vec++; if (d2_timeout !== 16'hFFD1) begin n_err++; $display("FAIL sat_mid: got %h want ffd1", d2_timeout); end
            end
            if (nlog == 100) begin
               n_vec++; if (d2_timeout !== 16'hFFFF) begin n_err++; $display("FAIL sat_at100: got %h want ffff", d2_timeout); end
            end
            t_prev = c;
         end
         @(negedge clk);
      end
      n_vec++; if (nlog !== 100) begin n_err++; $display("FAIL sat_budget: got %0d log_new want 100", nlog); end
      d2_valid = '0;
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if (d2_timeout !== 16'hFFFF) begin n_err++; $display("FAIL sat_final: got %h want ffff", d2_timeout); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_busy_hold();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/diag_log_scheduler.md
DIAG_LOG_SCHEDULER -- requirements
Module: diag_log_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of diagnostic requesters (legal 2..8).
REQ-002 SHALL have parameter MIN_GAP, default 16, minimum idle clk cycles between two logger samples (0 legal).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 64, clk cycles allowed for logger busy to rise after a sample pulse (legal 1..65535).
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NREQ  per-requester sample pending; held until accepted.
REQ-008 req_page  in  NREQ*8  flat bus; slice i = page of requester i.
REQ-009 req_value  in  NREQ*16  flat bus; slice i = value of requester i.
REQ-010 req_ready  out  NREQ  one-hot accept strobe; transfer on valid&ready.
REQ-011 i2c_busy  in  1  logger busy.
REQ-012 log_new  out  1  one-cycle sample strobe to logger.
REQ-013 log_page  out  8  page presented with log_new, held until next sample.
REQ-014 log_value  out  16  value presented with log_new, held until next sample.
REQ-015 grant_idx  out  3  index of last accepted requester.
REQ-016 sched_busy  out  1  high whenever state is not IDLE.
REQ-017 timeout_cnt  out  16  saturating count of busy-rise timeouts.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-019 IDLE: when i2c_busy=0 and any req_valid=1, SHALL drive req_ready (combinational) to the round-robin winner only, capture its page/value and index at that edge, go ISSUE.
REQ-020 IDLE with i2c_busy=1 SHALL grant nothing (logger externally busy).
REQ-021 Round-robin: search starts at last_grant+1, wraps modulo NREQ; last_grant updates on every accept.
REQ-022 ISSUE: log_new=1 for exactly one cycle with captured page/value; then WAIT_BUSY, cycle counter cleared.
REQ-023 WAIT_BUSY: i2c_busy=1 -> WAIT_DONE; counter reaching BUSY_TIMEOUT without busy -> timeout_cnt+1 (saturate 0xFFFF), go GAP.
REQ-024 WAIT_DONE: i2c_busy=0 -> GAP; no timeout in this state.
REQ-025 GAP: count MIN_GAP cycles then IDLE; MIN_GAP=0 SHALL pass GAP in one cycle.
REQ-026 Latency: req_valid rising in IDLE (busy=0, gap elapsed) -> req_ready same cycle -> log_new next cycle.
REQ-027 At most one req_ready bit high per cycle; req_ready all zero outside IDLE.
REQ-028 Requester deasserting valid before ready SHALL simply lose arbitration; no partial capture.
REQ-029 Requesters not granted SHALL keep valid; no sample dropped or duplicated by the scheduler.
REQ-030 Internal counters 16 bits; comparisons unsigned.

Reset
REQ-031 reset SHALL force: state IDLE, log_new 0, log_page 0, log_value 0, req_ready 0, grant_idx 0, sched_busy 0, timeout_cnt 0, last_grant NREQ-1 (requester 0 wins first).
REQ-032 reset mid-transaction SHALL abandon it with no further log_new; requester held valid is re-arbitrated after reset.

Structure
REQ-033 Package diag_log_pkg SHALL hold the state enum, NREQ_MAX=8, page width 8, value width 16, counter width 16.
REQ-034 Round-robin selection SHALL be sub-module rr_pick (inputs request vector, last index; outputs one-hot grant, index, any).
REQ-035 No other sub-modules; single always-block FSM plus counters.

Verification
REQ-036 Single request: req_valid=0001, page 0x05, value 0x1234, busy rises 3 cycles after log_new, held 10 -> one ready pulse, one log_new with 0x05/0x1234, timeout_cnt 0.
REQ-037 All four valid continuously, MIN_GAP=16 -> grant order 0,1,2,3,0; log_new spacing >= busy time + 16 + 2 cycles.
REQ-038 busy never rises, BUSY_TIMEOUT=64 -> timeout_cnt=1 after 64 cycles in WAIT_BUSY, scheduler returns IDLE after GAP, next grant proceeds.
REQ-039 i2c_busy held 1 in IDLE with req_valid=0010 -> no ready until busy falls; then ready[1] same cycle.
REQ-040 reset asserted during WAIT_DONE -> next cycle all outputs at reset values; requester 2 still valid -> granted first after reset released if 0,1 idle.
REQ-041 100 forced timeouts with counter preset near 0xFFFF -> timeout_cnt holds 0xFFFF.
